// File: rtl/v850_insn_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the V850 instruction aligner.
// The master drives fetch beats, flush and insn_ready; the slave (the aligner) answers.
interface v850_insn_aligner_if #(
  parameter int unsigned FETCH_W = 32
);
  logic [FETCH_W-1:0] fetch_data;
  logic               fetch_valid;
  logic               fetch_ready;
  logic               flush;
  logic [31:0]        flush_pc;
  logic [47:0]        insn;
  logic [1:0]         insn_len;
  logic [31:0]        insn_pc;
  logic               insn_valid;
  logic               insn_ready;
  logic               insn_illegal;

  modport master (
    output fetch_data, fetch_valid, flush, flush_pc, insn_ready,
    input  fetch_ready, insn, insn_len, insn_pc, insn_valid, insn_illegal
  );

  modport slave (
    input  fetch_data, fetch_valid, flush, flush_pc, insn_ready,
    output fetch_ready, insn, insn_len, insn_pc, insn_valid, insn_illegal
  );
endinterface

// File: rtl/v850_insn_aligner.sv
// V850 fetch aligner: halfword circular queue, 16/32/48-bit length decode, PC-tagged output.
// Optional macro V850_ILLEGAL_DET_EN builds the DIVH-r0 / all-ones illegal detector.
module v850_insn_aligner #(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                clk,
  input logic                rst_n,
  v850_insn_aligner_if.slave bus
);
  localparam int unsigned BEAT_HW = FETCH_W / 16;
  localparam int unsigned PW      = $clog2(QDEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned SW      = $clog2(FETCH_W / 8) - 1;

  logic [15:0]   mem_q [QDEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW-1:0] rd1, rd2;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_push;
  logic [25:0]   pc_q;
  logic [SW-1:0] skip_q;
  logic [15:0]   h0, h1, h2;
  logic [1:0]    len;
  logic          valid, push, pop;
  logic          unused_pc;

  assign unused_pc = ^{bus.flush_pc[31:26], bus.flush_pc[0]};

  assign rd1 = rd_q + PW'(1);
  assign rd2 = rd_q + PW'(2);
  assign h0  = mem_q[rd_q];
  assign h1  = mem_q[rd1];
  assign h2  = mem_q[rd2];

  // 48-bit forms are checked first: MOV imm32 also satisfies the 32-bit opcode range.
  always_comb begin
    len = 2'd1;
    if (h0[15:5] == 11'b00000110001 || h0 == 16'h02E0) begin
      len = 2'd3;
    end else if (h0[10:5] >= 6'b110000) begin
      len = 2'd2;
    end
  end

  assign valid           = !bus.flush && (count_q >= CW'(len));
  assign bus.fetch_ready = (CW'(QDEPTH) - count_q) >= CW'(BEAT_HW);
  assign push            = bus.fetch_valid && bus.fetch_ready && !bus.flush;
  assign pop             = valid && bus.insn_ready;
  assign n_push          = CW'(BEAT_HW) - CW'(skip_q);

  always_comb begin
    count_d = count_q;
    if (push) count_d = count_d + n_push;
    if (pop)  count_d = count_d - CW'(len);
  end

  always_comb begin
    bus.insn     = '0;
    bus.insn_len = 2'd0;
    if (valid) begin
      bus.insn_len     = len;
      bus.insn[15:0]   = h0;
      if (len >= 2'd2) bus.insn[31:16] = h1;
      if (len == 2'd3) bus.insn[47:32] = h2;
    end
  end

  assign bus.insn_valid = valid;
  assign bus.insn_pc    = {{6{pc_q[25]}}, pc_q};

`ifdef V850_ILLEGAL_DET_EN
  assign bus.insn_illegal = valid && (h0 == 16'hFFFF ||
                            (h0[10:5] == 6'b000010 && (h0[4:0] == 5'd0 || h0[15:11] == 5'd0)));
`else
  assign bus.insn_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC[25:0];
      skip_q  <= '0;
    end else if (bus.flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      pc_q    <= {bus.flush_pc[25:1], 1'b0};
      skip_q  <= bus.flush_pc[SW:1];
    end else begin
      if (push) begin
        // Halfwords below the redirect target inside the first beat are dropped.
        for (int i = 0; i < int'(BEAT_HW); i++) begin
          if (i >= int'(skip_q)) begin
            mem_q[wr_q + PW'(i) - PW'(skip_q)] <= bus.fetch_data[16*i +: 16];
          end
        end
        wr_q   <= wr_q + PW'(n_push);
        skip_q <= '0;
      end
      if (pop) begin
        rd_q <= rd_q + PW'(len);
        pc_q <= pc_q + {23'd0, len, 1'b0};
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_v850_insn_aligner.sv
// Bench for v850_insn_aligner: halfword-queue reference model checked every cycle,
// directed literal scenarios, randomized traffic and a mid-run asynchronous reset.
module tb_v850_insn_aligner;
  localparam int unsigned FETCH_W = 32;
  localparam int unsigned QDEPTH  = 8;
  localparam int unsigned BEAT_HW = FETCH_W / 16;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef V850_ILLEGAL_DET_EN
  localparam bit ILL_ON = 1'b1;
`else
  localparam bit ILL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  v850_insn_aligner_if #(.FETCH_W(FETCH_W)) bus ();

  v850_insn_aligner #(
    .FETCH_W (FETCH_W),
    .QDEPTH  (QDEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of halfwords plus a 26-bit head PC.
  logic [15:0] q[$];
  logic [25:0] mpc;
  int          mskip;

  function automatic int len_of(logic [15:0] h);
    if (h[15:5] == 11'h031 || h == 16'h02E0) return 3;
    if (h[10:5] >= 6'd48) return 2;
    return 1;
  endfunction

  function automatic bit illegal_of(logic [15:0] h);
    return (h == 16'hFFFF) || (h[10:5] == 6'd2 && (h[4:0] == 5'd0 || h[15:11] == 5'd0));
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc   = RESET_PC[25:0];
    mskip = 0;
  endtask

  task automatic drive(bit fv, logic [FETCH_W-1:0] fd, bit fl, logic [31:0] fpc, bit ir);
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.flush       = fl;
    bus.flush_pc    = fpc;
    bus.insn_ready  = ir;
    #1;
  endtask

  // Compare every output against the model at the falling edge, then advance the model.
  task automatic cyc();
    int          n;
    bit          ev, er;
    logic [47:0] e_insn;
    logic [1:0]  e_len;
    @(negedge clk);
    n  = (q.size() > 0) ? len_of(q[0]) : 1;
    ev = !bus.flush && (q.size() >= n);
    er = (int'(QDEPTH) - q.size()) >= int'(BEAT_HW);
    e_insn = '0;
    e_len  = 2'd0;
    if (ev) begin
      e_len = 2'(n);
      for (int i = 0; i < n; i++) e_insn[16*i +: 16] = q[i];
    end
    chk("fetch_ready", bus.fetch_ready, er);
    chk("insn_valid", bus.insn_valid, ev);
    chk("insn_len", bus.insn_len, e_len);
    chk("insn", bus.insn, e_insn);
    chk("insn_pc", bus.insn_pc, {{6{mpc[25]}}, mpc});
    chk("insn_illegal", bus.insn_illegal, ILL_ON && ev && illegal_of(q[0]));
    if (bus.flush) begin
      q.delete();
      mpc   = {bus.flush_pc[25:1], 1'b0};
      mskip = int'((bus.flush_pc >> 1) & (BEAT_HW - 1));
    end else begin
      if (ev && bus.insn_ready) begin
        for (int i = 0; i < n; i++) void'(q.pop_front());
        mpc = mpc + 26'(2 * n);
      end
      if (bus.fetch_valid && er) begin
        for (int i = mskip; i < int'(BEAT_HW); i++) q.push_back(bus.fetch_data[16*i +: 16]);
        mskip = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_insn(string name, logic [47:0] ins, logic [1:0] len, logic [31:0] pc);
    chk({name, ".valid"}, bus.insn_valid, 1'b1);
    chk({name, ".insn"}, bus.insn, ins);
    chk({name, ".len"}, bus.insn_len, len);
    chk({name, ".pc"}, bus.insn_pc, pc);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    case ($urandom_range(0, 7))
      0:       h = {11'h031, 5'($urandom)};
      1:       h = 16'h02E0;
      2:       h = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0040;
      3:       h = {5'($urandom), 6'b110000 | 6'($urandom_range(0, 15)), 5'($urandom)};
      default: h = 16'($urandom);
    endcase
    return h;
  endfunction

  task automatic random_phase(int cycles);
    logic [FETCH_W-1:0] d;
    logic [31:0]        fpc;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < int'(BEAT_HW); i++) d[16*i +: 16] = rand_hw();
      fpc = $urandom;
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 31) == 0, fpc,
            $urandom_range(0, 9) < 6);
      cyc();
    end
  endtask

  initial begin
    model_reset();
    drive(0, '0, 0, '0, 0);
    @(posedge clk);
    #1;
    chk("rst.insn_valid", bus.insn_valid, 1'b0);
    chk("rst.insn_len", bus.insn_len, 2'd0);
    chk("rst.insn", bus.insn, 48'h0);
    chk("rst.insn_illegal", bus.insn_illegal, 1'b0);
    chk("rst.insn_pc", bus.insn_pc, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.fetch_ready", bus.fetch_ready, 1'b1);

    // Two 16-bit instructions from one beat.
    drive(1, 32'h0002_01CE, 0, '0, 0); cyc();
    drive(0, '0, 0, '0, 1);
    expect_insn("hw0", 48'h01CE, 2'd1, 32'h0);
    cyc();
    drive(0, '0, 0, '0, 1);
    expect_insn("hw1", 48'h0002, 2'd1, 32'h2);
    cyc();

    // ADDI: 32-bit, pc advances by 4.
    drive(1, 32'h1234_0E00, 0, '0, 0); cyc();
    drive(0, '0, 0, '0, 1);
    expect_insn("addi", 48'h1234_0E00, 2'd2, 32'h4);
    cyc();
    drive(0, '0, 0, '0, 1);
    chk("addi.next_pc", bus.insn_pc, 32'h8);
    cyc();

    // MOV imm32 split over two beats.
    drive(1, 32'hAAAA_0625, 0, '0, 0); cyc();
    drive(0, '0, 0, '0, 0);
    chk("mov.partial_valid", bus.insn_valid, 1'b0);
    cyc();
    drive(1, 32'h0002_BBBB, 0, '0, 0); cyc();
    drive(0, '0, 0, '0, 1);
    expect_insn("mov", 48'hBBBB_AAAA_0625, 2'd3, 32'h8);
    cyc();
    drive(0, '0, 0, '0, 1);
    expect_insn("mov.next", 48'h0002, 2'd1, 32'hE);
    cyc();

    // Flush with a beat in the same cycle; the next beat's low halfword is skipped.
    drive(1, 32'h1111_2222, 1, 32'h0000_0102, 1);
    chk("flush.valid_forced", bus.insn_valid, 1'b0);
    cyc();
    drive(1, 32'h0006_0004, 0, '0, 0); cyc();
    drive(0, '0, 0, '0, 1);
    expect_insn("flush.first", 48'h0006, 2'd1, 32'h0000_0102);
    cyc();
    drive(0, '0, 0, '0, 1);
    chk("flush.empty", bus.insn_valid, 1'b0);
    cyc();

    // Fill to full with decode stalled, then drain across the 26-bit PC wrap.
    drive(0, '0, 1, 32'h01FF_FFF8, 0); cyc();
    for (int k = 0; k < 4; k++) begin
      drive(1, {16'(2 * k + 2), 16'(2 * k + 1)}, 0, '0, 0);
      chk("fill.ready", bus.fetch_ready, 1'b1);
      cyc();
    end
    drive(1, 32'hDEAD_BEEF, 0, '0, 0);
    chk("full.fetch_ready", bus.fetch_ready, 1'b0);
    chk("full.insn_valid", bus.insn_valid, 1'b1);
    cyc();
    for (int k = 0; k < 8; k++) begin
      drive(0, '0, 0, '0, 1);
      chk("drain.insn", bus.insn, 48'(k + 1));
      if (k == 3) chk("drain.pc_top", bus.insn_pc, 32'h01FF_FFFE);
      if (k == 4) chk("drain.pc_wrap", bus.insn_pc, 32'hFE00_0000);
      cyc();
    end

    // DIVH r0,r0.
    drive(0, '0, 1, 32'h0, 0); cyc();
    drive(1, 32'h0000_0040, 0, '0, 0); cyc();
    drive(0, '0, 0, '0, 1);
    chk("divh.illegal", bus.insn_illegal, ILL_ON);
    chk("divh.len", bus.insn_len, 2'd1);
    cyc();

    random_phase(3000);

    // Asynchronous reset mid-traffic.
    drive(1, 32'h0002_0002, 0, '0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst.insn_valid", bus.insn_valid, 1'b0);
    chk("arst.insn", bus.insn, 48'h0);
    chk("arst.insn_pc", bus.insn_pc, RESET_PC);
    model_reset();
    drive(0, '0, 0, '0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    random_phase(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
